dp_control_unit: RTL

Multi-cycle sequencer for the 4-bit datapath, i.e. the program counter, the 4x4 register file and the 4-bit ALU.
- Fetches one 16-bit instruction per pass through a valid/request handshake and latches it in an internal instruction register (IR).
- Decodes the IR and drives register-file addresses, the register file's active-low write strobe, the ALU op/cin/binv controls and the PC increment pulse.
- Sits between instruction memory and the datapath; it is the only driver of those datapath controls.

---
 rtl/dp_cu_pkg.sv | 37 +++
 rtl/dp_cu_decode.sv | 65 ++++++
 rtl/dp_control_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dp_cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_cu_pkg
// Brief    : Shared types and constants for the 4-bit datapath control unit:
//            sequencer state encoding, instruction opcodes and ALU selects.
// Revision : 1.0 - initial release
// ============================================================================
package dp_cu_pkg;

    // Sequencer states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // Instruction opcodes
    localparam logic [3:0] OPC_AND  = 4'h0;
    localparam logic [3:0] OPC_OR   = 4'h1;
    localparam logic [3:0] OPC_ADD  = 4'h2;
    localparam logic [3:0] OPC_SUB  = 4'h3;
    localparam logic [3:0] OPC_SLT  = 4'h4;
    localparam logic [3:0] OPC_NOP  = 4'h5;
    localparam logic [3:0] OPC_HALT = 4'hF;

    // ALU function selects
    localparam logic [1:0] ALU_AND = 2'd0;
    localparam logic [1:0] ALU_OR  = 2'd1;
    localparam logic [1:0] ALU_ADD = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

endpackage : dp_cu_pkg
`default_nettype wire

// File: rtl/dp_cu_decode.sv
`default_nettype none
// ============================================================================
// Module   : dp_cu_decode
// Brief    : Combinational opcode decoder. Maps a 4-bit opcode onto the ALU
//            op/cin/binv controls, the register-file write enable and the
//            halt indication. Unknown opcodes behave as NOP.
// Revision : 1.0 - initial release
// ============================================================================
module dp_cu_decode
    import dp_cu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [1:0] o_op,
    output logic       o_cin,
    output logic       o_binv,
    output logic       o_writes,
    output logic       o_is_halt
);

    // Opcode table; SUB and SLT subtract by inverting B and forcing carry-in
    always_comb begin
        o_op      = ALU_AND;
        o_cin     = 1'b0;
        o_binv    = 1'b0;
        o_writes  = 1'b0;
        o_is_halt = 1'b0;
        case (i_opcode)
            OPC_AND: begin
                o_op     = ALU_AND;
                o_writes = 1'b1;
            end
            OPC_OR: begin
                o_op     = ALU_OR;
                o_writes = 1'b1;
            end
            OPC_ADD: begin
                o_op     = ALU_ADD;
                o_writes = 1'b1;
            end
            OPC_SUB: begin
                o_op     = ALU_ADD;
                o_cin    = 1'b1;
                o_binv   = 1'b1;
                o_writes = 1'b1;
            end
            OPC_SLT: begin
                o_op     = ALU_SLT;
                o_cin    = 1'b1;
                o_binv   = 1'b1;
                o_writes = 1'b1;
            end
            OPC_NOP: begin
                o_op = ALU_AND;
            end
            OPC_HALT: begin
                o_is_halt = 1'b1;
            end
            default: begin
                o_op = ALU_AND;
            end
        endcase
    end

endmodule : dp_cu_decode
`default_nettype wire

// File: rtl/dp_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : dp_control_unit
// Brief    : Multi-cycle sequencer for the 4-bit datapath (PC, 4x4 register
//            file, 4-bit ALU). Fetches a 16-bit instruction through a
//            valid/request handshake, then walks READ -> EXEC -> WB driving
//            the register-file addresses/strobe, ALU controls and PC pulse.
//            Optional macro DP_CU_RETIRE_CNT_EN builds a saturating count of
//            retired instructions; otherwise retired_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dp_control_unit
    import dp_cu_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 8,
    parameter int unsigned OPC_LSB       = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        instr_valid,
    input  logic [15:0] instruction,
    output logic        instr_req,
    output logic        pc_inc,
    output logic [1:0]  rf_ra1,
    output logic [1:0]  rf_ra2,
    output logic [1:0]  rf_wa,
    output logic        wr,
    output logic [1:0]  op,
    output logic        cin,
    output logic        binv,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [7:0]  retired_cnt
);

    localparam logic [3:0] c_tmo_limit = FETCH_TIMEOUT[3:0];

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [3:0]  r_tmo_cnt;
    logic [3:0]  w_tmo_next;

    logic [1:0]  w_dec_op;
    logic        w_dec_cin;
    logic        w_dec_binv;
    logic        w_dec_writes;
    logic        w_dec_is_halt;
    logic        w_alu_phase;
    logic        w_unused_ir;

    assign w_tmo_next = r_tmo_cnt + 4'd1;

    dp_cu_decode u_decode (
        .i_opcode  (r_ir[OPC_LSB +: 4]),
        .o_op      (w_dec_op),
        .o_cin     (w_dec_cin),
        .o_binv    (w_dec_binv),
        .o_writes  (w_dec_writes),
        .o_is_halt (w_dec_is_halt)
    );

    // State register, instruction register and fetch-stall counter
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state   <= IDLE;
            r_ir      <= 16'd0;
            r_tmo_cnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == FETCH) begin
                if (instr_valid) begin
                    r_ir      <= instruction;
                    r_tmo_cnt <= 4'd0;
                end else begin
                    r_tmo_cnt <= w_tmo_next;
                end
            end
        end
    end

    // Next-state logic; HALTED and ERROR hold until reset
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = FETCH;
            end
            FETCH: begin
                if (instr_valid)                    w_next_state = READ;
                else if (w_tmo_next == c_tmo_limit) w_next_state = ERROR;
            end
            READ:    w_next_state = EXEC;
            EXEC:    w_next_state = w_dec_is_halt ? HALTED : WB;
            WB:      w_next_state = FETCH;
            HALTED:  w_next_state = HALTED;
            ERROR:   w_next_state = ERROR;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded purely from the registered state and IR
    assign w_alu_phase = (r_state == EXEC) || (r_state == WB);

    assign instr_req = (r_state == FETCH);
    assign pc_inc    = (r_state == WB);
    assign wr        = ~((r_state == WB) && w_dec_writes);
    assign op        = w_alu_phase ? w_dec_op   : ALU_AND;
    assign cin       = w_alu_phase ? w_dec_cin  : 1'b0;
    assign binv      = w_alu_phase ? w_dec_binv : 1'b0;
    assign busy      = (r_state == FETCH) || (r_state == READ) ||
                       (r_state == EXEC)  || (r_state == WB);
    assign halted    = (r_state == HALTED);
    assign err       = (r_state == ERROR);

    assign rf_ra1 = r_ir[7:6];
    assign rf_ra2 = r_ir[5:4];
    assign rf_wa  = r_ir[3:2];

    // Whole word is kept in IR; bits outside the decoded fields are unused
    assign w_unused_ir = &{1'b0, r_ir};

`ifdef DP_CU_RETIRE_CNT_EN
    logic [7:0] r_retired_cnt;

    // Saturating count of instructions reaching write-back (HALT never does)
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_retired_cnt <= 8'd0;
        end else if ((r_state == WB) && (r_retired_cnt != 8'hFF)) begin
            r_retired_cnt <= r_retired_cnt + 8'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`else
    assign retired_cnt = 8'd0;
`endif

endmodule : dp_control_unit
`default_nettype wire
